// File: rtl/iob_fifo_ram_ctrl_if.sv
// Handshake, status and RAM-port bundle between iob_fifo_ram_ctrl and its neighbours.
// master = the FIFO controller, slave = producer/consumer/RAM side.
interface iob_fifo_ram_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
);
   logic              w_en;
   logic [DATA_W-1:0] w_data;
   logic              w_full;
   logic              w_almost_full;

   logic              r_en;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_empty;
   logic              r_almost_empty;

   logic [ADDR_W:0]   level;

   logic              ram_en_a;
   logic              ram_we_a;
   logic [ADDR_W-1:0] ram_addr_a;
   logic [DATA_W-1:0] ram_data_a;

   logic              ram_en_b;
   logic              ram_we_b;
   logic [ADDR_W-1:0] ram_addr_b;
   logic [DATA_W-1:0] ram_data_b;
   logic [DATA_W-1:0] ram_q_b;

   modport master (
      input  w_en, w_data, r_en, ram_q_b,
      output w_full, w_almost_full, r_data, r_valid, r_empty, r_almost_empty, level,
      output ram_en_a, ram_we_a, ram_addr_a, ram_data_a,
      output ram_en_b, ram_we_b, ram_addr_b, ram_data_b
   );

   modport slave (
      output w_en, w_data, r_en, ram_q_b,
      input  w_full, w_almost_full, r_data, r_valid, r_empty, r_almost_empty, level,
      input  ram_en_a, ram_we_a, ram_addr_a, ram_data_a,
      input  ram_en_b, ram_we_b, ram_addr_b, ram_data_b
   );
endinterface

// File: rtl/iob_fifo_ram_ctrl.sv
// Synchronous FIFO controller driving an external true-dual-port RAM (A = write, B = read).
// Define IOB_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module iob_fifo_ram_ctrl #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 11,
   parameter int ALM_FULL_LVL  = 2**ADDR_W-4,
   parameter int ALM_EMPTY_LVL = 4
) (
   input  logic clk,
   input  logic rst_n,
`ifdef IOB_FIFO_ERR_EN
   input  logic err_clr,
   output logic overflow,
   output logic underflow,
`endif
   iob_fifo_ram_ctrl_if.master bus
);
   localparam logic [ADDR_W:0] DEPTH_L     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ALM_FULL_L  = (ADDR_W+1)'(ALM_FULL_LVL);
   localparam logic [ADDR_W:0] ALM_EMPTY_L = (ADDR_W+1)'(ALM_EMPTY_LVL);

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              r_valid_q;

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] w_data_s;

   // Flags come from the registered level, so they lag the causing event by one cycle.
   assign full     = (level_q == DEPTH_L);
   assign empty    = (level_q == '0);
   assign push     = bus.w_en & ~full;
   assign pop      = bus.r_en & ~empty;
   assign w_data_s = bus.w_data;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         r_valid_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         r_valid_q <= pop;
      end
   end

   assign bus.w_full         = full;
   assign bus.w_almost_full  = (level_q >= ALM_FULL_L);
   assign bus.r_empty        = empty;
   assign bus.r_almost_empty = (level_q <= ALM_EMPTY_L);
   assign bus.level          = level_q;
   assign bus.r_valid        = r_valid_q;
   assign bus.r_data         = bus.ram_q_b;

   assign bus.ram_en_a   = push;
   assign bus.ram_we_a   = push;
   assign bus.ram_addr_a = wptr_q;
   assign bus.ram_data_a = w_data_s;

   assign bus.ram_en_b   = pop;
   assign bus.ram_we_b   = 1'b0;
   assign bus.ram_addr_b = rptr_q;
   assign bus.ram_data_b = '0;

`ifdef IOB_FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // A new error outranks a clear arriving in the same cycle.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.w_en & full) begin
         overflow_d = 1'b1;
      end
      if (bus.r_en & empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_iob_fifo_ram_ctrl.sv
// Bench for iob_fifo_ram_ctrl (depth 8): queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized push/pop traffic.
module tb_iob_fifo_ram_ctrl;
   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;
   localparam int AEMPT = 2;

   logic clk;
   logic rst_n;
`ifdef IOB_FIFO_ERR_EN
   logic err_clr;
   logic overflow;
   logic underflow;
`endif

   int n_tests;
   int n_fail;

   iob_fifo_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   iob_fifo_ram_ctrl #(
      .DATA_W        (DW),
      .ADDR_W        (AW),
      .ALM_FULL_LVL  (AFULL),
      .ALM_EMPTY_LVL (AEMPT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef IOB_FIFO_ERR_EN
      .err_clr   (err_clr),
      .overflow  (overflow),
      .underflow (underflow),
`endif
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port RAM with registered read, standing in for the attached block RAM.
   logic [DW-1:0] ram_mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (bus.ram_en_a && bus.ram_we_a) ram_mem[bus.ram_addr_a] <= bus.ram_data_a;
      if (bus.ram_en_b) bus.ram_q_b <= ram_mem[bus.ram_addr_b];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: contents as a queue, pointers as running push/pop counts.
   logic [DW-1:0] m_q[$];
   int            m_wcnt;
   int            m_rcnt;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;
   logic          m_ovf;
   logic          m_unf;

   initial begin
      int  lvl;
      logic m_push, m_pop;
      m_wcnt = 0; m_rcnt = 0; m_rvalid = 1'b0; m_rdata = '0; m_ovf = 1'b0; m_unf = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_q.delete();
            m_wcnt = 0; m_rcnt = 0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         end
         lvl = m_q.size();
         chk("level", 32'(bus.level), 32'(lvl));
         chk("r_empty", 32'(bus.r_empty), 32'(lvl == 0));
         chk("w_full", 32'(bus.w_full), 32'(lvl == DEPTH));
         chk("w_almost_full", 32'(bus.w_almost_full), 32'(lvl >= AFULL));
         chk("r_almost_empty", 32'(bus.r_almost_empty), 32'(lvl <= AEMPT));
         chk("r_valid", 32'(bus.r_valid), 32'(m_rvalid));
         if (m_rvalid) chk("r_data", 32'(bus.r_data), 32'(m_rdata));
`ifdef IOB_FIFO_ERR_EN
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("underflow", 32'(underflow), 32'(m_unf));
`endif
         if (rst_n) begin
            m_push = bus.w_en && (lvl < DEPTH);
            m_pop  = bus.r_en && (lvl > 0);
            chk("ram_en_a", 32'(bus.ram_en_a), 32'(m_push));
            chk("ram_we_a", 32'(bus.ram_we_a), 32'(m_push));
            chk("ram_en_b", 32'(bus.ram_en_b), 32'(m_pop));
            chk("ram_we_b", 32'(bus.ram_we_b), 32'd0);
            chk("ram_data_b", 32'(bus.ram_data_b), 32'd0);
            if (m_push) begin
               chk("ram_addr_a", 32'(bus.ram_addr_a), 32'(m_wcnt % DEPTH));
               chk("ram_data_a", 32'(bus.ram_data_a), 32'(bus.w_data));
            end
            if (m_pop) chk("ram_addr_b", 32'(bus.ram_addr_b), 32'(m_rcnt % DEPTH));
`ifdef IOB_FIFO_ERR_EN
            if (err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (bus.w_en && lvl == DEPTH) m_ovf = 1'b1;
            if (bus.r_en && lvl == 0) m_unf = 1'b1;
`endif
            if (m_pop) begin
               m_rdata = m_q.pop_front();
               m_rcnt++;
            end
            m_rvalid = m_pop;
            if (m_push) begin
               m_q.push_back(bus.w_data);
               m_wcnt++;
            end
         end
      end
   end

   task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      @(posedge clk);
      #1;
      bus.w_en   = w;
      bus.r_en   = r;
      bus.w_data = d;
`ifdef IOB_FIFO_ERR_EN
      err_clr    = c;
`else
      if (c) bus.w_data = d;
`endif
      #1;
   endtask

   initial begin
      int bias_w, bias_r;
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0;
      bus.w_en = 1'b0; bus.r_en = 1'b0; bus.w_data = '0;
`ifdef IOB_FIFO_ERR_EN
      err_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst level", 32'(bus.level), 32'd0);
      chk("rst r_empty", 32'(bus.r_empty), 32'd1);
      chk("rst r_almost_empty", 32'(bus.r_almost_empty), 32'd1);
      chk("rst w_full", 32'(bus.w_full), 32'd0);
      chk("rst w_almost_full", 32'(bus.w_almost_full), 32'd0);
      chk("rst r_valid", 32'(bus.r_valid), 32'd0);
      rst_n = 1'b1;

      // Fill to full, overfill, simultaneous at full, then drain.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
      drive(1'b1, 1'b0, 8'd8, 1'b0);
      chk("full level", 32'(bus.level), 32'd8);
      chk("full w_full", 32'(bus.w_full), 32'd1);
      chk("full push dropped", 32'(bus.ram_en_a), 32'd0);
      drive(1'b1, 1'b1, 8'd9, 1'b0);
      chk("full both en_a", 32'(bus.ram_en_a), 32'd0);
      chk("full both en_b", 32'(bus.ram_en_b), 32'd1);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      chk("after full both level", 32'(bus.level), 32'd7);
      chk("first pop data", 32'(bus.r_data), 32'h00);
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("drained r_empty", 32'(bus.r_empty), 32'd1);
      chk("last pop data", 32'(bus.r_data), 32'h07);

      // Simultaneous at level 0.
      drive(1'b1, 1'b1, 8'h3C, 1'b0);
      chk("empty both en_a", 32'(bus.ram_en_a), 32'd1);
      chk("empty both en_b", 32'(bus.ram_en_b), 32'd0);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      chk("empty both level", 32'(bus.level), 32'd1);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("empty both data", 32'(bus.r_data), 32'h3C);

      // Simultaneous at level 3.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
      drive(1'b1, 1'b1, 8'h50, 1'b0);
      chk("lvl3 both en_a", 32'(bus.ram_en_a), 32'd1);
      chk("lvl3 both en_b", 32'(bus.ram_en_b), 32'd1);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("lvl3 both level", 32'(bus.level), 32'd3);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);

      // Pointer wrap with interleaved push/pop.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, DW'($urandom), 1'b0);
         drive(1'b0, 1'b1, 8'd0, 1'b0);
         chk("wrap level<=2", 32'(bus.level <= 2), 32'd1);
      end
      drive(1'b0, 1'b0, 8'd0, 1'b0);

      // Reset in the middle of a pop with r_valid pending.
      drive(1'b1, 1'b0, 8'h11, 1'b0);
      drive(1'b1, 1'b0, 8'h22, 1'b0);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      @(posedge clk);
      #3;
      bus.w_en = 1'b0; bus.r_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst level", 32'(bus.level), 32'd0);
      chk("midrst r_empty", 32'(bus.r_empty), 32'd1);
      chk("midrst r_valid", 32'(bus.r_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 8'hA5, 1'b0);
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      chk("A5 pop cycle r_valid", 32'(bus.r_valid), 32'd0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("A5 r_valid", 32'(bus.r_valid), 32'd1);
      chk("A5 r_data", 32'(bus.r_data), 32'hA5);

`ifdef IOB_FIFO_ERR_EN
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("underflow set", 32'(underflow), 32'd1);
      drive(1'b0, 1'b0, 8'd0, 1'b1);
      chk("underflow sticky", 32'(underflow), 32'd1);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("underflow cleared", 32'(underflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
      drive(1'b1, 1'b0, 8'd0, 1'b0);
      drive(1'b1, 1'b0, 8'd0, 1'b1);
      chk("overflow set", 32'(overflow), 32'd1);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("overflow set beats clr", 32'(overflow), 32'd1);
      drive(1'b0, 1'b0, 8'd0, 1'b1);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      chk("overflow cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
`endif

      // Randomized traffic with phase-varying bias to visit full and empty.
      bias_w = 50; bias_r = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            bias_w = $urandom_range(20, 90);
            bias_r = $urandom_range(20, 90);
         end
         drive($urandom_range(0, 99) < bias_w, $urandom_range(0, 99) < bias_r,
               DW'($urandom), $urandom_range(0, 9) == 0);
      end
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/iob_fifo_ram_ctrl.md
# iob_fifo_ram_ctrl

Synchronous FIFO controller that acts as the initiator on a true-dual-port RAM's two ports. It uses port A as a write-only port and port B as a read-only port. The controller owns the pointers, the occupancy counter, the flags and the push/pop handshakes. The RAM is instantiated beside it and connected through the `ram_*` ports. It serves as the buffering stage between producer and consumer blocks sharing one clock domain.

## Interface
Parameters:
- `DATA_W`, 32, data word width; must match the attached RAM.
- `ADDR_W`, 11, RAM address width; FIFO depth is 2**ADDR_W.
- `ALM_FULL_LVL`, 2**ADDR_W-4, `w_almost_full` asserts when level >= this value.
- `ALM_EMPTY_LVL`, 4, `r_almost_empty` asserts when level <= this value.

Ports (name, direction, width, meaning):
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: single clock; all state updates on its rising edge.
  - `rst_n` in 1: asynchronous, active-low reset.
- Write side:
  - `w_en` in 1: push request.
  - `w_data` in DATA_W: push data.
  - `w_full` out 1: FIFO full.
  - `w_almost_full` out 1: level >= ALM_FULL_LVL.
- Read side:
  - `r_en` in 1: pop request.
  - `r_data` out DATA_W: popped word; equals `ram_q_b`.
  - `r_valid` out 1: `r_data` holds the word of the pop accepted in the previous cycle.
  - `r_empty` out 1: FIFO empty.
  - `r_almost_empty` out 1: level <= ALM_EMPTY_LVL.
- Status:
  - `level` out ADDR_W+1: current occupancy, 0..2**ADDR_W.
- RAM port A (write):
  - `ram_en_a` out 1.
  - `ram_we_a` out 1.
  - `ram_addr_a` out ADDR_W.
  - `ram_data_a` out DATA_W.
- RAM port B (read):
  - `ram_en_b` out 1.
  - `ram_we_b` out 1: tied 0.
  - `ram_addr_b` out ADDR_W.
  - `ram_data_b` out DATA_W: tied 0.
  - `ram_q_b` in DATA_W: RAM registered read data, 1-cycle latency.

## Operation
- Push accept: `push = w_en & ~w_full`.
  - Drives `ram_en_a = ram_we_a = push`, `ram_addr_a = wptr`, `ram_data_a = w_data`, all combinationally.
  - `wptr` increments on accept.
- Pop accept: `pop = r_en & ~r_empty`.
  - Drives `ram_en_b = pop`, `ram_addr_b = rptr`, combinationally.
  - `rptr` increments on accept.
- Rejected requests are dropped silently: no pointer or level change, no RAM enable.
- Pointers are ADDR_W bits wide and wrap modulo 2**ADDR_W, from 2**ADDR_W-1 to 0.
- `level` update (registered):
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Flags are decoded from the `level` register, so they change the cycle after the causing event:
  - `w_full = (level == 2**ADDR_W)`.
  - `r_empty = (level == 0)`.
- Simultaneous push and pop:
  - Level 0: pop rejected, push accepted; level becomes 1.
  - Level full: push rejected, pop accepted; level becomes 2**ADDR_W-1.
  - Otherwise: both accepted; level unchanged.
- Port A and port B never address the same word in the same cycle, because pop requires level >= 1. No read-during-write hazard exists.
- `r_valid` is a register loaded with `pop` each cycle.
- `r_data` is not registered in this block; it is stable only while `r_valid` = 1.

## Timing
- Reset values (asynchronous, on `rst_n` = 0):
  - `wptr` = `rptr` = 0, `level` = 0.
  - `r_empty` = 1, `r_almost_empty` = 1.
  - `w_full` = 0, `w_almost_full` = 0 (unless ALM_FULL_LVL = 0).
  - `r_valid` = 0.
  - Error flags = 0.
- RAM contents are not cleared. `r_data` is undefined after reset until the first `r_valid`.
- Push-to-pop latency: a word pushed in cycle N can be popped in cycle N+1, since `r_empty` deasserts at N+1. Its data appears on `r_data` with `r_valid` = 1 at cycle N+2.
- Pop-to-data latency: exactly 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight `r_valid` is cleared and no data is reported.

## Configuration
- Macro `IOB_FIFO_ERR_EN`.
- When defined, three extra ports are present:
  - `err_clr` in 1.
  - `overflow` out 1: sticky; set the cycle after `w_en & w_full`.
  - `underflow` out 1: sticky; set the cycle after `r_en & r_empty`.
- `err_clr` clears both sticky flags. If `err_clr` and a new error occur in the same cycle, set wins.
- When undefined, these ports and their registers do not exist, and rejected requests leave no trace.

## Test plan
- Reset check (ADDR_W=3): assert `rst_n` = 0 mid-stream -> immediately `level` = 0, `r_empty` = 1, `r_valid` = 0; after release, push 0xA5 then pop -> `r_data` = 0xA5 with `r_valid` = 1 exactly one cycle after the pop.
- Fill to full (ADDR_W=3): push 0..7, then push 8 -> `w_full` = 1 from the cycle after push 7, push 8 dropped, `level` = 8; pop 8 times -> data 0..7 in order, `r_empty` = 1 after the last pop.
- Pointer wrap: 20 interleaved push/pop pairs on depth 8 -> data order preserved across wrap, `level` never exceeds 2.
- Simultaneous push and pop:
  - At level 0 -> only the push is accepted, `level` = 1, `ram_en_b` = 0.
  - At full -> only the pop is accepted, `level` = 7.
  - At level 3 -> both are accepted, `level` stays 3.
- Almost flags (ALM_FULL_LVL=6, ALM_EMPTY_LVL=2): step level 0..8..0 -> `w_almost_full` is 1 exactly for levels 6..8, `r_almost_empty` is 1 exactly for levels 0..2.
- With `IOB_FIFO_ERR_EN`: pop when empty -> `underflow` = 1 and sticky; push when full -> `overflow` = 1; `err_clr` pulse -> both flags 0; `err_clr` in the same cycle as a new overflow -> `overflow` stays 1.
